// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: state encoding,
// frame geometry and line idle level.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam int FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_READ  = READ,
    S_LOAD  = LOAD,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick marks the last cycle of each UART bit, pre_tick
// the cycle before it so registered outputs can line up with the last cycle.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next count: hold at zero while cleared, wrap after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = (cnt_q == LAST);
  assign pre_tick = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO read port and sends each as a UART
// 8N1 frame; every output is a flop fed from the next-state decode.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int DATA_BITS = FRAME_BITS - 2;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t state_d, state_q;
  logic [DATA_W-1:0] shift_d, shift_q;
  logic [2:0] bit_d, bit_q;
  logic tx_d, tx_q;
  logic rd_en_d, rd_en_q;
  logic busy_d, busy_q;
  logic done_d, done_q;
  logic baud_clr, tick, pre_tick;

  // The bit timer only runs while a frame is on the line, so START always
  // begins from a count of zero.
  assign baud_clr = (state_q == S_IDLE) || (state_q == S_READ) || (state_q == S_LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_data;
        state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = (enable && !fifo_empty) ? S_READ : S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = IDLE_LEVEL;
    endcase

    rd_en_d = (state_d == S_READ);
    busy_d  = (state_d != S_IDLE);
    // pre_tick in STOP lands the registered pulse on the final STOP cycle.
    done_d  = (state_q == S_STOP) && pre_tick;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= 3'd0;
      tx_q    <= IDLE_LEVEL;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, a line
// monitor decodes frames and checks them against the bytes written.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic rst, enable, wr_en;
  logic [7:0] wr_data;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_rd_en, tx, busy, tx_done;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int gaps_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // Behavioural sync_fifo: data_out valid the cycle after rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: decodes the tx line sampled on the falling edge.
  initial begin
    int phase, idx, c, last_end, bi;
    bit ok, rd_prev;
    logic [7:0] byt;
    logic lvl;
    phase = 0; idx = 0; c = 0; last_end = -1; ok = 1'b1; rd_prev = 1'b0; byt = 8'h00;
    forever begin
      @(negedge clk);
      c++;
      if (rst !== 1'b1) begin
        phase = 0;
        last_end = -1;
        rd_prev = 1'b0;
      end else begin
        if (fifo_rd_en === 1'b1) begin
          rd_cnt++;
          check("rd_while_empty", int'(fifo_empty), 0);
          check("rd_single_cycle", int'(rd_prev), 0);
        end
        rd_prev = (fifo_rd_en === 1'b1);
        if (phase == 0) begin
          if (tx_done === 1'b1) check("done_outside_frame", int'(tx_done), 0);
          if (busy === 1'b0) last_end = -1;
          if (tx === 1'b0) begin
            phase = 1; idx = 0; ok = 1'b1; byt = 8'h00;
            if (last_end >= 0) gaps_q.push_back(c - last_end - 1);
          end
        end
        if (phase == 1) begin
          bi = idx / CPB;
          if (bi == 0) lvl = 1'b0;
          else if (bi == 9) lvl = 1'b1;
          else begin
            if (idx % CPB == 0) byt[bi-1] = tx;
            lvl = byt[bi-1];
          end
          if (tx !== lvl) ok = 1'b0;
          if ((tx_done === 1'b1) != (idx == FRAME_CYC - 1)) ok = 1'b0;
          if (busy !== 1'b1) ok = 1'b0;
          idx++;
          if (idx == FRAME_CYC) begin
            check("frame_shape", int'(ok), 1);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_frame: actual=0x%02h required=none", byt);
            end else begin
              check("frame_byte", int'(byt), int'(exp_q.pop_front()));
            end
            phase = 0;
            last_end = c;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_tx_low(input int lim);
    int n = 0;
    while (tx !== 1'b0 && n < lim) begin step(); n++; end
    check("start_seen", int'(tx === 1'b0), 1);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && fifo_empty === 1'b1) && n < lim) begin
      step();
      n++;
    end
    check("drained", int'(exp_q.size() == 0 && busy === 1'b0), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_tx", int'(tx), 1);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_done", int'(tx_done), 0);
  endtask

  initial begin
    int rd_base, n;
    bit tx_hi;
    rst = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_data = 8'h00;

    // Reset with a byte queued: nothing moves until release.
    step();
    check_reset_outputs();
    push_byte(8'h5A);
    check_reset_outputs();
    step();
    check_reset_outputs();
    rst = 1'b1;
    step();
    check("rd_after_release", int'(fifo_rd_en), 1);
    wait_drain(200);

    // Single byte: latency, one read pulse, tx_done then idle.
    rd_base = rd_cnt;
    push_byte(8'h11);
    check("lat_rd_early", int'(fifo_rd_en), 0);
    step();
    check("lat_rd", int'(fifo_rd_en), 1);
    check("lat_tx_read", int'(tx), 1);
    step();
    check("lat_rd_drop", int'(fifo_rd_en), 0);
    check("lat_busy_load", int'(busy), 1);
    step();
    check("lat_tx_start", int'(tx), 0);
    n = 0;
    while (tx_done !== 1'b1 && n < 60) begin step(); n++; end
    check("done_seen", int'(tx_done), 1);
    step();
    check("idle_busy", int'(busy), 0);
    check("idle_tx", int'(tx), 1);
    check("single_rd_count", rd_cnt - rd_base, 1);

    // Four back-to-back bytes.
    gaps_q.delete();
    rd_base = rd_cnt;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_drain(400);
    check("b2b_rd_count", rd_cnt - rd_base, 4);
    check("b2b_gap_count", gaps_q.size(), 3);
    foreach (gaps_q[i]) check("b2b_gap", gaps_q[i], 2);
    check("b2b_fifo_level", fq.size(), 0);

    // enable dropped mid-DATA: frame completes, next byte waits.
    push_byte(8'hA5);
    wait_tx_low(20);
    repeat (8) step();
    enable = 1'b0;
    push_byte(8'h3C);
    n = 0;
    while (busy !== 1'b0 && n < 60) begin step(); n++; end
    check("dis_busy_clear", int'(busy), 0);
    rd_base = rd_cnt;
    tx_hi = 1'b1;
    repeat (20) begin step(); if (tx !== 1'b1) tx_hi = 1'b0; end
    check("dis_no_rd", rd_cnt - rd_base, 0);
    check("dis_tx_idle", int'(tx_hi), 1);
    check("dis_byte_held", int'(fifo_empty), 0);
    enable = 1'b1;
    step();
    check("en_rd", int'(fifo_rd_en), 1);
    wait_drain(200);

    // Reset mid-frame aborts 0x33; the following byte still goes out.
    push_byte(8'h33);
    push_byte(8'h55);
    wait_tx_low(20);
    repeat (10) step();
    rst = 1'b0;
    step();
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    void'(exp_q.pop_front());
    rst = 1'b1;
    wait_drain(200);

    // Empty FIFO: no reads, line stays idle.
    rd_base = rd_cnt;
    tx_hi = 1'b1;
    repeat (100) begin step(); if (tx !== 1'b1) tx_hi = 1'b0; end
    check("empty_no_rd", rd_cnt - rd_base, 0);
    check("empty_tx_idle", int'(tx_hi), 1);

    // Randomized bytes, spacing and enable.
    repeat (24) begin
      enable = ($urandom_range(0, 3) != 0);
      push_byte(8'($urandom));
      repeat ($urandom_range(0, 60)) step();
    end
    enable = 1'b1;
    wait_drain(24 * 50 + 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
